sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Sequencer between the front-panel command logic and the cryogenic SRAM pins. It accepts single-word write and read requests, drives address, data and strobes through a fixed three-phase access whose phase length is set by a runtime clock factor, and captures read data from the SRAM output bus. It owns the SRAM pin timing, so the command/display logic only issues requests and consumes results.

## Interface
- ADDR_W, 8, SRAM address width (drives JA)
- DATA_W, 8, SRAM data width (drives JB, sampled from JC)
- CF_W, 8, clk_factor width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  write request, single-cycle pulse
- rd_req  in  1  read request, single-cycle pulse
- addr  in  ADDR_W  access address, sampled at acceptance
- wdata  in  DATA_W  write data, sampled at acceptance
- clk_factor  in  CF_W  phase length in clk cycles; 0 is treated as 1
- busy  out  1  transaction in progress or pending
- done  out  1  one-cycle pulse at the end of each transaction
- rdata  out  DATA_W  last captured read word; held until the next read
- rdata_valid  out  1  one-cycle pulse coincident with done for reads
- sram_addr  out  ADDR_W  SRAM address bus
- sram_din  out  DATA_W  SRAM write-data bus
- sram_we  out  1  write strobe
- sram_re  out  1  read strobe
- sram_clk  out  1  SRAM access clock
- sram_dout  in  DATA_W  SRAM read-data bus
- mismatch  out  1  readback mismatch flag (see Configuration)

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: a request is accepted on a rising clk edge with wr_req or rd_req high and no pending request. Acceptance latches addr, wdata, op and N = max(clk_factor, 1). Requests while busy are ignored; no queueing except the pending case below.
- Simultaneous wr_req and rd_req: the write runs first and the read is latched as pending, using the same addr. DONE goes directly to SETUP for the read, and busy stays high throughout.
- SETUP, N cycles: sram_addr and sram_din are driven; sram_we, sram_re and sram_clk are low.
- STROBE, N cycles: sram_clk is high and sram_we (write) or sram_re (read) is high. On the last STROBE cycle of a read, sram_dout is registered into rdata.
- HOLD, N cycles: strobes and sram_clk are low; address and data are still held.
- DONE, 1 cycle: done=1 and rdata_valid=1 for reads. Next state is IDLE, or SETUP if a read is pending.
- sram_addr and sram_din keep their last values in IDLE. They change only at acceptance and are latched whole, with no partial-bit update.
- The phase counter is CF_W bits, counts N-1 down to 0, and does not wrap. N=255 is legal.

## Timing
- Reset (async assert): state IDLE and all outputs 0, including rdata, sram_addr, sram_din and mismatch. Pending request and latched N are cleared. Reset mid-transaction aborts with no done pulse.
- Latency from the acceptance edge to the done pulse is 3N+1 cycles. busy rises on the cycle after acceptance and falls on the cycle after the last DONE.
- clk_factor changes during a transaction take effect only at the next acceptance.
- rd/wr pulses must be synchronous and debounced upstream.

## Configuration
- SRAM_READBACK_VERIFY_EN:
  - Defined: every write is followed automatically by a read of the same address, using the same sequence. done pulses once, after the readback. rdata is updated. mismatch is set if the readback differs from wdata; it is sticky and cleared only by rst or the next accepted write. Latency becomes 6N+2.
  - Undefined: mismatch is tied to 0 and a write ends after a single pass.

## Structure
- Package sram_ctrl_pkg holds the state enum (IDLE, SETUP, STROBE, HOLD, DONE), the op encoding (OP_WR, OP_RD) and the default widths.
- Sub-module sram_phase_timer: loads N, counts down, and asserts phase_end. Instantiated once.

## Test plan
- Reset mid-access: assert rst during STROBE with clk_factor=4 -> all outputs 0 immediately, no done pulse, and the next request runs normally.
- Write: addr=0xCD, wdata=0xEF, clk_factor=2, wr_req pulse -> sram_we high for exactly 2 cycles in STROBE with sram_addr=0xCD and sram_din=0xEF; done pulses 7 cycles after acceptance.
- Read: sram_dout=0xAB, rd_req, clk_factor=0 -> N=1, rdata=0xAB, rdata_valid pulses with done 4 cycles after acceptance.
- Simultaneous wr_req and rd_req with addr=0x80 and sram_dout=0xFF:
  - Write sequence runs, then the read sequence runs, with busy continuously high.
  - done pulses twice.
  - rdata=0xFF.
- Address integrity: write 0xFF, then write addr 0x00, then read addr 0x80 -> sram_addr is exactly 0x80 for all of SETUP/STROBE/HOLD, with no residual bits.
- With SRAM_READBACK_VERIFY_EN: write 0x5A while sram_dout=0x5B -> mismatch=1 after done, latency 6N+2; a following write of 0x5B with matching dout clears mismatch.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and default widths for the SRAM access sequencer.
//   state_e : sequencer states IDLE, SETUP, STROBE, HOLD, DONE
//   op_e    : transaction kind OP_WR / OP_RD
//   *_DEF   : default address, data and clock-factor widths
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CF_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

endpackage

// File: rtl/sram_phase_timer.sv
// ---------------------------------------------------------------------------
// sram_phase_timer
// Down-counter that times one access phase. A load sets the count to N-1,
// the count then decrements once per clock and parks at zero (no wrap).
// phase_end_o is high while the count is zero, i.e. on the last cycle of
// the phase.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   load_i       : reload the counter from n_i (n_i is never 0)
//   n_i          : phase length in clock cycles
//   phase_end_o  : current cycle is the last cycle of the phase
// ---------------------------------------------------------------------------
module sram_phase_timer #(
  parameter int CF_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CF_W-1:0] n_i,
  output logic            phase_end_o
);

  logic [CF_W-1:0] cnt_q;

  // Load N-1 so that a phase lasts exactly N cycles including the load cycle's successor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= n_i - CF_W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CF_W'(1);
    end
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
// Sequencer between the command logic and the SRAM pins. Each accepted
// request runs SETUP / STROBE / HOLD phases of N = max(clk_factor,1) cycles
// each, followed by a one-cycle DONE. Read data is captured on the last
// STROBE cycle of a read. A simultaneous write+read runs the write first
// and then the read at the same address, with busy held high throughout.
//
// Optional feature, macro SRAM_READBACK_VERIFY_EN:
//   every write is followed by an automatic readback of the same address;
//   done pulses only after the readback, and mismatch is set (sticky until
//   rst or the next accepted write) when the readback differs from wdata.
//   Without the macro, mismatch is tied low.
//
// Ports:
//   clk, rst            : system clock, asynchronous active-high reset
//   wr_req, rd_req      : single-cycle request pulses
//   addr, wdata         : sampled at acceptance
//   clk_factor          : phase length, sampled at acceptance (0 -> 1)
//   busy, done          : transaction status / end-of-transaction pulse
//   rdata, rdata_valid  : last captured read word / pulse with done on reads
//   sram_addr, sram_din : SRAM address and write-data buses
//   sram_we, sram_re    : SRAM write / read strobes
//   sram_clk            : SRAM access clock (high during STROBE)
//   sram_dout           : SRAM read-data bus
//   mismatch            : readback mismatch flag
// ---------------------------------------------------------------------------
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CF_W   = CF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CF_W-1:0]   clk_factor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  output logic              sram_re,
  output logic              sram_clk,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              mismatch
);

`ifdef SRAM_READBACK_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  state_e            state_q;
  op_e               op_q;
  logic              pendRd_q;
  logic [CF_W-1:0]   n_q;
  logic              busy_q;
  logic              done_q;
  logic              rdataValid_q;
  logic              sramWe_q;
  logic              sramRe_q;
  logic              sramClk_q;
  logic [ADDR_W-1:0] sramAddr_q;
  logic [DATA_W-1:0] sramDin_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              phaseEnd;
  logic              timerLoad;
  logic [CF_W-1:0]   nAccept;
  logic [CF_W-1:0]   timerN;

  assign accept  = (state_q == IDLE) && (wr_req || rd_req);
  assign nAccept = (clk_factor == '0) ? CF_W'(1) : clk_factor;

  // The timer is reloaded whenever a new phase starts: at acceptance (with the
  // fresh clk_factor), on the SETUP->STROBE and STROBE->HOLD transitions, and
  // when DONE chains into the pending read (with the latched N).
  always_comb begin
    timerLoad = 1'b0;
    timerN    = n_q;
    if (accept) begin
      timerLoad = 1'b1;
      timerN    = nAccept;
    end else if ((state_q == SETUP || state_q == STROBE) && phaseEnd) begin
      timerLoad = 1'b1;
    end else if (state_q == DONE && pendRd_q) begin
      timerLoad = 1'b1;
    end
  end

  sram_phase_timer #(
    .CF_W (CF_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (timerLoad),
    .n_i         (timerN),
    .phase_end_o (phaseEnd)
  );

  // Sequencer with registered pin outputs: every output register is updated on
  // the same edge as the state change, so the pins line up with the state.
  // In readback-verify builds the write pass ends in a silent DONE cycle that
  // chains straight into the readback pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_WR;
      pendRd_q     <= 1'b0;
      n_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdataValid_q <= 1'b0;
      sramWe_q     <= 1'b0;
      sramRe_q     <= 1'b0;
      sramClk_q    <= 1'b0;
      sramAddr_q   <= '0;
      sramDin_q    <= '0;
      rdata_q      <= '0;
    end else begin
      done_q       <= 1'b0;
      rdataValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= SETUP;
            busy_q     <= 1'b1;
            sramAddr_q <= addr;
            sramDin_q  <= wdata;
            n_q        <= nAccept;
            op_q       <= wr_req ? OP_WR : OP_RD;
            pendRd_q   <= wr_req && (rd_req || VerifyEn);
          end
        end
        SETUP: begin
          if (phaseEnd) begin
            state_q   <= STROBE;
            sramClk_q <= 1'b1;
            sramWe_q  <= (op_q == OP_WR);
            sramRe_q  <= (op_q == OP_RD);
          end
        end
        STROBE: begin
          if (phaseEnd) begin
            state_q   <= HOLD;
            sramClk_q <= 1'b0;
            sramWe_q  <= 1'b0;
            sramRe_q  <= 1'b0;
            if (op_q == OP_RD) begin
              rdata_q <= sram_dout;
            end
          end
        end
        HOLD: begin
          if (phaseEnd) begin
            state_q      <= DONE;
            done_q       <= !((op_q == OP_WR) && VerifyEn);
            rdataValid_q <= (op_q == OP_RD);
          end
        end
        DONE: begin
          if (pendRd_q) begin
            state_q  <= SETUP;
            op_q     <= OP_RD;
            pendRd_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_READBACK_VERIFY_EN
  logic rbPass_q;
  logic mismatch_q;

  // rbPass_q marks that the next read capture is the automatic readback of a
  // write; only that capture is compared against the written word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbPass_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else if (accept && wr_req) begin
      rbPass_q   <= 1'b1;
      mismatch_q <= 1'b0;
    end else if (state_q == STROBE && phaseEnd && op_q == OP_RD && rbPass_q) begin
      rbPass_q   <= 1'b0;
      mismatch_q <= (sram_dout != sramDin_q);
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign sram_addr   = sramAddr_q;
  assign sram_din    = sramDin_q;
  assign sram_we     = sramWe_q;
  assign sram_re     = sramRe_q;
  assign sram_clk    = sramClk_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_access_ctrl
// Directed and randomized transactions against sram_access_ctrl. Expected
// pin activity is derived from the phase arithmetic: a transaction is a list
// of passes (write and/or read), each pass is N setup + N strobe + N hold
// cycles plus one DONE cycle, counted from the acceptance edge.
// ---------------------------------------------------------------------------
module tb_sram_access_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] clk_factor;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic [7:0] sram_addr;
  logic [7:0] sram_din;
  logic       sram_we;
  logic       sram_re;
  logic       sram_clk;
  logic [7:0] sram_dout;
  logic       mismatch;

  int checks;
  int errors;

`ifdef SRAM_READBACK_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  // Reference state that outlives a single transaction.
  logic [7:0] rdExp;
  logic       mmExp;

  sram_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .addr        (addr),
    .wdata       (wdata),
    .clk_factor  (clk_factor),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .sram_addr   (sram_addr),
    .sram_din    (sram_din),
    .sram_we     (sram_we),
    .sram_re     (sram_re),
    .sram_clk    (sram_clk),
    .sram_dout   (sram_dout),
    .mismatch    (mismatch)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"},     32'(busy),        32'd0);
    checkOutput({tag, ".done"},     32'(done),        32'd0);
    checkOutput({tag, ".rvalid"},   32'(rdata_valid), 32'd0);
    checkOutput({tag, ".rdata"},    32'(rdata),       32'd0);
    checkOutput({tag, ".addr"},     32'(sram_addr),   32'd0);
    checkOutput({tag, ".din"},      32'(sram_din),    32'd0);
    checkOutput({tag, ".we"},       32'(sram_we),     32'd0);
    checkOutput({tag, ".re"},       32'(sram_re),     32'd0);
    checkOutput({tag, ".sclk"},     32'(sram_clk),    32'd0);
    checkOutput({tag, ".mismatch"}, 32'(mismatch),    32'd0);
  endtask

  // Runs one transaction starting from an idle cycle (called #1 after an edge)
  // and checks every cycle until the controller is idle again.
  task automatic applyStimulus(input bit w, input bit r, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] cf,
                               input logic [7:0] so);
    int  n;
    int  plen;
    int  npass;
    int  total;
    bit  opRd [2];
    n     = (cf == 8'd0) ? 1 : int'(cf);
    plen  = 3 * n + 1;
    npass = 0;
    if (w) begin
      opRd[npass] = 1'b0;
      npass++;
    end
    if (r || (w && VerifyEn)) begin
      opRd[npass] = 1'b1;
      npass++;
    end
    total = npass * plen;
    if (w) mmExp = VerifyEn && (so != d);

    sram_dout  = so;
    addr       = a;
    wdata      = d;
    clk_factor = cf;
    wr_req     = w;
    rd_req     = r;
    @(posedge clk); #1;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    addr       = 8'($urandom);
    wdata      = 8'($urandom);
    clk_factor = 8'($urandom);

    for (int k = 0; k < total; k++) begin
      int p;
      int j;
      bit rdp;
      bit inStrobe;
      bit isDone;
      p        = k / plen;
      j        = k % plen;
      rdp      = opRd[p];
      inStrobe = (j >= n) && (j < 2 * n);
      isDone   = (j == 3 * n);
      if (rdp && j >= 2 * n) rdExp = so;
      // A request while busy must be ignored.
      if (k == 1) begin
        rd_req = 1'b1;
        addr   = 8'($urandom);
      end
      if (k == 2) rd_req = 1'b0;

      checkOutput("busy",   32'(busy),        32'd1);
      checkOutput("sclk",   32'(sram_clk),    32'(inStrobe));
      checkOutput("we",     32'(sram_we),     32'(inStrobe && !rdp));
      checkOutput("re",     32'(sram_re),     32'(inStrobe && rdp));
      checkOutput("addr",   32'(sram_addr),   32'(a));
      checkOutput("din",    32'(sram_din),    32'(d));
      checkOutput("done",   32'(done),        32'(isDone && (rdp || !VerifyEn)));
      checkOutput("rvalid", 32'(rdata_valid), 32'(isDone && rdp));
      checkOutput("rdata",  32'(rdata),       32'(rdExp));
      @(posedge clk); #1;
    end

    checkOutput("end.busy",     32'(busy),        32'd0);
    checkOutput("end.done",     32'(done),        32'd0);
    checkOutput("end.rvalid",   32'(rdata_valid), 32'd0);
    checkOutput("end.we",       32'(sram_we),     32'd0);
    checkOutput("end.re",       32'(sram_re),     32'd0);
    checkOutput("end.addr",     32'(sram_addr),   32'(a));
    checkOutput("end.din",      32'(sram_din),    32'(d));
    checkOutput("end.rdata",    32'(rdata),       32'(rdExp));
    checkOutput("end.mismatch", 32'(mismatch),    32'(mmExp));
  endtask

  // Directed scenarios first, then a randomized sweep.
  initial begin
    checks     = 0;
    errors     = 0;
    rdExp      = 8'h00;
    mmExp      = 1'b0;
    rst        = 1'b1;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    addr       = 8'h00;
    wdata      = 8'h00;
    clk_factor = 8'h00;
    sram_dout  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a STROBE phase with N=4.
    addr       = 8'h3C;
    wdata      = 8'hA5;
    clk_factor = 8'd4;
    wr_req     = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("midrst.we", 32'(sram_we), 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      checkOutput("midrst.nodone", 32'(done), 32'd0);
      checkOutput("midrst.idle",   32'(busy), 32'd0);
    end
    rdExp = 8'h00;
    mmExp = 1'b0;

    applyStimulus(1'b1, 1'b0, 8'hCD, 8'hEF, 8'd2, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h12, 8'h34, 8'd0, 8'hAB);
    applyStimulus(1'b1, 1'b1, 8'h80, 8'h11, 8'd3, 8'hFF);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF, 8'd1, 8'hFF);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'd1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h00, 8'd1, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h5A, 8'd2, 8'h5B);
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h5B, 8'd2, 8'h5B);
    applyStimulus(1'b0, 1'b1, 8'hE1, 8'h00, 8'd255, 8'hC3);

    for (int i = 0; i < 20; i++) begin
      bit w;
      bit r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!w && !r) r = 1'b1;
      applyStimulus(w, r, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
